pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the five-stage core. Detects load-use hazards on the decode stage's two register-file read ports, holds the front of the pipeline for multi-cycle execute operations (mult/div), and sequences flushes on exception or redirect. Drives the per-stage stall vector consumed by the pc, if/id, id/ex, ex/mem and mem/wb registers.

Parameters:
CNT_W, 5, width of the multi-cycle count input and internal down-counter
STALL_W, 6, stall vector width; bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
id_reg1_read_i  in  1  decode stage reads port 1
id_reg1_addr_i  in  5  decode stage port-1 register address
id_reg2_read_i  in  1  decode stage reads port 2
id_reg2_addr_i  in  5  decode stage port-2 register address
ex_is_load_i  in  1  instruction in EX is a load
ex_wreg_i  in  1  instruction in EX writes a register
ex_wd_i  in  5  destination register of instruction in EX
ex_multi_start_i  in  1  EX begins a multi-cycle operation (1-cycle pulse)
ex_multi_cycles_i  in  CNT_W  total stall cycles needed by that operation
flush_i  in  1  exception/redirect flush request
stall_o  out  STALL_W  per-stage hold vector
flush_o  out  1  registered flush pulse to all pipeline registers
busy_o  out  1  FSM not in IDLE
stall_cycles_o  out  32  saturating count of cycles with stall_o[0]=1

Behaviour:
- Reset (rst low, async): state IDLE, cnt 0, flush_o 0, stall_cycles_o 0; stall_o forced 0 while rst low; busy_o 0.
- hz (combinational) = ex_is_load_i & ex_wreg_i & (ex_wd_i != 0) & ((id_reg1_read_i & id_reg1_addr_i == ex_wd_i) | (id_reg2_read_i & id_reg2_addr_i == ex_wd_i)). Register 0 never causes a hazard.
- States: IDLE, MULTI, FLUSH. stall_o is Mealy (state + current inputs); state, cnt, flush_o are registered.
- Priority in any state: flush_i > ex_multi_start_i > hz.
- flush_i=1 (any state): stall_o=0 this cycle; next edge state<=FLUSH, cnt<=0, flush_o<=1. Aborts MULTI immediately.
- FLUSH: flush_o=1 for exactly this cycle; stall_o=0; hz and ex_multi_start_i ignored; next IDLE (or FLUSH again if flush_i=1).
- IDLE, ex_multi_start_i=1: cycles=0 -> no stall, stay IDLE. cycles=1 -> stall_o=6'b001111 this cycle only, stay IDLE. cycles>=2 -> stall_o=6'b001111, next MULTI with cnt<=cycles-1.
- IDLE, hz=1 (no start): stall_o=6'b000111 for this cycle (pc/if/id held, bubble into EX); stay IDLE. Hazard clears naturally as load advances.
- IDLE otherwise: stall_o=0.
- MULTI: stall_o=6'b001111; hz and ex_multi_start_i ignored; if cnt==1 next IDLE else cnt<=cnt-1. Total held cycles from start pulse = ex_multi_cycles_i exactly.
- flush_o is 0 except in FLUSH state.
- busy_o = (state != IDLE).
- stall_cycles_o increments on each edge where stall_o[0]=1; saturates at 32'hFFFFFFFF; cleared only by reset.
- Reset asserted mid-MULTI or mid-FLUSH: immediate return to IDLE, outputs to reset values, no residual flush pulse.

Test Plan:
- Load-use: ex_is_load=1, ex_wreg=1, ex_wd=5, id_reg2_read=1, id_reg2_addr=5 for one cycle -> stall_o=6'b000111 that cycle, 0 next; stall_cycles_o=1.
- Register zero: same as above with ex_wd=0 and reg1_addr=0 -> stall_o stays 0.
- Multi-cycle: ex_multi_start=1, cycles=4 -> stall_o=6'b001111 for exactly 4 cycles, busy_o=1 for cycles 2-4, then IDLE; cycles=1 -> 1 stall cycle, busy_o never 1; cycles=0 -> no stall.
- Flush mid-MULTI: start cycles=10, flush_i at 3rd stall cycle -> stall_o=0 that cycle, flush_o=1 next cycle only, then IDLE with stall_o=0.
- Priority: flush_i, ex_multi_start (cycles=3) and hz together -> stall_o=0, FLUSH next, no MULTI entered.
- Async reset during MULTI (cnt=6): rst low between edges -> stall_o, busy_o, flush_o, stall_cycles_o go 0 without a clock edge; after release, IDLE.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer: load-use hazards, multi-cycle EX hold, flush pulses
module pipe_ctrl #(
  parameter int CNT_W   = 5,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_reg1_read_i,
  input  logic [4:0]         id_reg1_addr_i,
  input  logic               id_reg2_read_i,
  input  logic [4:0]         id_reg2_addr_i,
  input  logic               ex_is_load_i,
  input  logic               ex_wreg_i,
  input  logic [4:0]         ex_wd_i,
  input  logic               ex_multi_start_i,
  input  logic [CNT_W-1:0]   ex_multi_cycles_i,
  input  logic               flush_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic               busy_o,
  output logic [31:0]        stall_cycles_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULTI = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [STALL_W-1:0] STALL_HZ    = STALL_W'(6'b000111);
  localparam logic [STALL_W-1:0] STALL_MULTI = STALL_W'(6'b001111);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [STALL_W-1:0] stall_c;
  logic               hz;

  // r0 is hardwired zero, so a load targeting it can never be a real dependency
  assign hz = ex_is_load_i & ex_wreg_i & (ex_wd_i != 5'd0) &
              ((id_reg1_read_i & (id_reg1_addr_i == ex_wd_i)) |
               (id_reg2_read_i & (id_reg2_addr_i == ex_wd_i)));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall_c = '0;
    if (flush_i) begin
      state_n = FLUSH;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_multi_start_i) begin
            if (ex_multi_cycles_i != '0) stall_c = STALL_MULTI;
            if (ex_multi_cycles_i > CNT_W'(1)) begin
              state_n = MULTI;
              cnt_n   = ex_multi_cycles_i - CNT_W'(1);
            end
          end else if (hz) begin
            stall_c = STALL_HZ;
          end
        end
        MULTI: begin
          stall_c = STALL_MULTI;
          if (cnt <= CNT_W'(1)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        FLUSH: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // stall must drop the moment reset asserts, not at the next edge
  assign stall_o = rst ? stall_c : '0;
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      flush_o        <= 1'b0;
      stall_cycles_o <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      flush_o <= flush_i;
      if (stall_o[0] && (stall_cycles_o != 32'hFFFF_FFFF))
        stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end

endmodule
